tictactoe_game_ctrl: RTL
========================

Name: tictactoe_game_ctrl

Overview:
- Upstream game-state engine for the tic-tac-toe display path.
- Turns debounced push-button moves and synchronized cell-select switches into the 9-cell board array that the VGA renderer consumes.
- Enforces turn order and move legality, and detects win/draw.
- Runs entirely on the pixel clock, so the board needs no clock-domain crossing.

Parameters:
- DEBOUNCE_CYCLES, 250000, cycles a raw button level must be stable before it is accepted (10 ms at 25 MHz).
- CNT_W, 18, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- iVGA_CLK  in  1  pixel clock; all logic is posedge.
- iRST_n  in  1  asynchronous active-low reset.
- iSel  in  4  cell-select switches, raw asynchronous; cells 0..8 are row-major.
- iCommit_n  in  1  raw active-low push button; place the current player's mark at iSel.
- iNewGame_n  in  1  raw active-low push button; clear the board and restart.
- board  out  2x9  unpacked [1:0] board [8:0]; 00 empty, 10 player 1, 11 player 2; 01 is never driven.
- oTurn  out  1  0 = player 1 to move, 1 = player 2 to move.
- oWinner  out  2  00 none, 10 player 1, 11 player 2.
- oDraw  out  1  high when the board is full with no winner.
- oGameOver  out  1  oWinner != 00 or oDraw.
- oIllegal  out  1  one-cycle pulse on a rejected commit.

Behaviour:
- Reset (asynchronous, iRST_n low):
  - All board cells 00; oTurn 0; oWinner 00; oDraw 0; oGameOver 0; oIllegal 0.
  - Move count 0; state PLAY; synchronizers and debounce counters cleared.
  - Debounced button levels reset to released (1).
  - Reset may be asserted at any time, including mid-CHECK; no partial state survives.
- Input conditioning:
  - iSel, iCommit_n and iNewGame_n each pass through a 2-flop synchronizer.
  - Each button then has a debouncer. The counter restarts whenever the synchronized level differs from the stable level. When the counter reaches DEBOUNCE_CYCLES-1, the stable level updates.
  - A stable 1->0 transition produces a one-cycle press pulse. Release produces no pulse; holding a button gives exactly one pulse.
- States: PLAY, CHECK, OVER.
- PLAY, on commit pulse:
  - Legal when sel < 9 and board[sel] == 00: write 10 (oTurn=0) or 11 (oTurn=1) on the next edge, increment the move count, go to CHECK.
  - Otherwise (sel >= 9 or cell occupied): oIllegal high for exactly one cycle; board, turn and state unchanged.
- CHECK (exactly one cycle): evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) for the mover's code only.
  - Any line complete: oWinner = mover's code, go to OVER; oTurn unchanged.
  - Else if move count == 9: oDraw = 1, go to OVER.
  - Else: toggle oTurn, go to PLAY.
  - Commit pulses arriving in CHECK are dropped; no oIllegal.
  - A win on the 9th move reports the winner, not a draw.
- OVER: commit pulses are ignored silently; the board is held.
- New-game pulse, in any state:
  - Next edge: board cleared, oTurn 0, oWinner 00, oDraw 0, count 0, state PLAY.
  - Wins over a commit pulse in the same cycle; that commit is discarded with no oIllegal.
- Latency:
  - Stable press to pulse: 2 sync cycles plus DEBOUNCE_CYCLES.
  - Pulse to board update: 1 cycle.
  - Board update to oWinner/oDraw/oTurn update: 1 cycle.
- All outputs are registered. oGameOver is a registered copy consistent with oWinner/oDraw in the same cycle.

Optional Feature:
- Macro TICTACTOE_WIN_MASK_EN.
- Defined:
  - Adds output oWinMask [8:0], one bit per cell, set for every cell on any completed winning line. Loaded in CHECK alongside oWinner.
  - Cleared by reset and by new game.
  - Two simultaneous lines (e.g. a row and a diagonal through the same move) set the union.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- tictactoe_pkg holds:
  - Cell codes CELL_EMPTY=2'b00, CELL_P1=2'b10, CELL_P2=2'b11, shared with the renderer.
  - The state enum {PLAY, CHECK, OVER}.
  - A constant 8-entry table of 3 cell indices per win line.
  - NUM_CELLS=9.
- Sub-module btn_debounce (synchronizer + debounce counter + falling-edge pulse), instantiated twice. iSel uses a bare 2-flop synchronizer.

Test Plan (DEBOUNCE_CYCLES=4 on the bench):
- Reset then release; press commit with iSel=4 -> board[4]=10 one cycle after the pulse; oTurn=1 one cycle later; no oIllegal.
- Commit sel 0,3,1,4,2 (P1 takes the top row) -> board[0..2]=10; oWinner=10, oGameOver=1 in the CHECK+1 cycle; a further commit with iSel=8 leaves board[8]=00.
- Commit iSel=4 twice -> second commit gives oIllegal for exactly 1 cycle; oTurn stays 1. Commit iSel=9 and iSel=15 -> oIllegal each time; board unchanged.
- Full draw sequence 0,1,2,4,3,5,7,6,8 -> oDraw=1, oWinner=00. Variant ending in a 9th-move win -> oWinner set, oDraw=0.
- Button bouncing (toggle every 2 cycles for 20 cycles, then held low) -> exactly one commit pulse. New-game and commit asserted in the same cycle -> board all 00, oIllegal=0.
- Assert iRST_n low for 1 cycle during CHECK -> all outputs at reset values immediately, state PLAY. With TICTACTOE_WIN_MASK_EN, the diagonal 0,4,8 win -> oWinMask=9'b100010001.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// rtl/tictactoe_pkg.sv - cell codes, FSM states and win-line table shared by the game controller and renderer
package tictactoe_pkg;

   localparam int NUM_CELLS = 9;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P1    = 2'b10;
   localparam logic [1:0] CELL_P2    = 2'b11;

   typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

   // Rows, columns, then diagonals; entry [l] holds the three cell indices of line l
   localparam logic [7:0][2:0][3:0] WIN_LINES = {
      {4'd2, 4'd4, 4'd6},
      {4'd0, 4'd4, 4'd8},
      {4'd2, 4'd5, 4'd8},
      {4'd1, 4'd4, 4'd7},
      {4'd0, 4'd3, 4'd6},
      {4'd6, 4'd7, 4'd8},
      {4'd3, 4'd4, 4'd5},
      {4'd0, 4'd1, 4'd2}
   };

   function automatic logic [NUM_CELLS-1:0] win_cells(input logic [NUM_CELLS-1:0][1:0] b,
                                                       input logic [1:0] code);
      logic [NUM_CELLS-1:0] m;
      m = '0;
      for (int l = 0; l < 8; l++) begin
         if (b[WIN_LINES[l][0]] == code && b[WIN_LINES[l][1]] == code &&
             b[WIN_LINES[l][2]] == code) begin
            m[WIN_LINES[l][0]] = 1'b1;
            m[WIN_LINES[l][1]] = 1'b1;
            m[WIN_LINES[l][2]] = 1'b1;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/tictactoe_game_ctrl_btn_debounce.sv
// rtl/tictactoe_game_ctrl_btn_debounce.sv - 2-flop synchronizer, debounce counter and press pulse for one active-low button
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn_n,
   output logic o_press
);

   logic [1:0]       r_sync;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             w_sync;
   logic             w_diff;
   logic             w_done;

   assign w_sync = r_sync[1];
   assign w_diff = (w_sync != r_stable);
   assign w_done = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

   // Synchronizer resets to the released level so reset release never looks like a press
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync   <= 2'b11;
         r_stable <= 1'b1;
         r_cnt    <= '0;
         o_press  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_btn_n};
         o_press <= w_done & ~w_sync;
         if (!w_diff || w_done) r_cnt <= '0;
         else                   r_cnt <= r_cnt + CNT_W'(1);
         if (w_done) r_stable <= w_sync;
      end
   end

endmodule

// File: rtl/tictactoe_game_ctrl.sv
// rtl/tictactoe_game_ctrl.sv - tic-tac-toe move/turn/win engine on the pixel clock
// Optional TICTACTOE_WIN_MASK_EN adds oWinMask marking the cells of completed winning lines.
module tictactoe_game_ctrl
   import tictactoe_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic       iVGA_CLK,
   input  logic       iRST_n,
   input  logic [3:0] iSel,
   input  logic       iCommit_n,
   input  logic       iNewGame_n,
   output logic [1:0] board [8:0],
   output logic       oTurn,
   output logic [1:0] oWinner,
   output logic       oDraw,
   output logic       oGameOver,
   output logic       oIllegal
`ifdef TICTACTOE_WIN_MASK_EN
   ,
   output logic [8:0] oWinMask
`endif
);

   logic [3:0]                r_sel_s1;
   logic [3:0]                r_sel;
   logic [3:0]                r_count;
   state_t                    r_state;
   state_t                    w_state_nxt;
   logic                      w_commit;
   logic                      w_newgame;
   logic                      w_place;
   logic                      w_illegal;
   logic                      w_set_win;
   logic                      w_set_draw;
   logic                      w_toggle;
   logic                      w_clear;
   logic [1:0]                w_mover;
   logic [NUM_CELLS-1:0][1:0] w_board_pk;
   logic [NUM_CELLS-1:0]      w_mask;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_commit_db (
      .i_clk(iVGA_CLK), .i_rst_n(iRST_n), .i_btn_n(iCommit_n), .o_press(w_commit)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_newgame_db (
      .i_clk(iVGA_CLK), .i_rst_n(iRST_n), .i_btn_n(iNewGame_n), .o_press(w_newgame)
   );

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_sel_s1 <= '0;
         r_sel    <= '0;
      end else begin
         r_sel_s1 <= iSel;
         r_sel    <= r_sel_s1;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CELLS; i++) w_board_pk[i] = board[i];
   end

   // Only the player who just moved can have completed a line
   assign w_mover = oTurn ? CELL_P2 : CELL_P1;
   assign w_mask  = win_cells(w_board_pk, w_mover);

   always_comb begin
      w_state_nxt = r_state;
      w_place     = 1'b0;
      w_illegal   = 1'b0;
      w_set_win   = 1'b0;
      w_set_draw  = 1'b0;
      w_toggle    = 1'b0;
      w_clear     = 1'b0;
      if (w_newgame) begin
         w_clear     = 1'b1;
         w_state_nxt = PLAY;
      end else begin
         case (r_state)
            PLAY: begin
               if (w_commit) begin
                  if (r_sel < 4'(NUM_CELLS) && board[r_sel] == CELL_EMPTY) begin
                     w_place     = 1'b1;
                     w_state_nxt = CHECK;
                  end else begin
                     w_illegal = 1'b1;
                  end
               end
            end
            CHECK: begin
               if (|w_mask) begin
                  w_set_win   = 1'b1;
                  w_state_nxt = OVER;
               end else if (r_count == 4'(NUM_CELLS)) begin
                  w_set_draw  = 1'b1;
                  w_state_nxt = OVER;
               end else begin
                  w_toggle    = 1'b1;
                  w_state_nxt = PLAY;
               end
            end
            OVER:    w_state_nxt = OVER;
            default: w_state_nxt = PLAY;
         endcase
      end
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         for (int i = 0; i < NUM_CELLS; i++) board[i] <= CELL_EMPTY;
         oTurn     <= 1'b0;
         oWinner   <= CELL_EMPTY;
         oDraw     <= 1'b0;
         oGameOver <= 1'b0;
         oIllegal  <= 1'b0;
         r_count   <= '0;
         r_state   <= PLAY;
`ifdef TICTACTOE_WIN_MASK_EN
         oWinMask  <= '0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         oIllegal <= w_illegal;
         if (w_clear) begin
            for (int i = 0; i < NUM_CELLS; i++) board[i] <= CELL_EMPTY;
            oTurn     <= 1'b0;
            oWinner   <= CELL_EMPTY;
            oDraw     <= 1'b0;
            oGameOver <= 1'b0;
            r_count   <= '0;
`ifdef TICTACTOE_WIN_MASK_EN
            oWinMask  <= '0;
`endif
         end else begin
            if (w_place) begin
               board[r_sel] <= w_mover;
               r_count      <= r_count + 4'd1;
            end
            if (w_set_win) begin
               oWinner   <= w_mover;
               oGameOver <= 1'b1;
`ifdef TICTACTOE_WIN_MASK_EN
               oWinMask  <= w_mask;
`endif
            end
            if (w_set_draw) begin
               oDraw     <= 1'b1;
               oGameOver <= 1'b1;
            end
            if (w_toggle) oTurn <= ~oTurn;
         end
      end
   end

endmodule
